div_unit: RTL

- Multi-cycle 32-bit integer divider in the EX stage; executes DIV/DIVU.
- Issues the EX-stage stall request that drives the pipeline controller's EX stall input, holding IF..EX frozen until the quotient and remainder are ready.
- Returns {remainder, quotient} for the HI/LO write path.

---
 rtl/div_unit_if.sv | 23 ++
 rtl/div_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Handshake and operand/result bundle between the EX stage and the multi-cycle divider.
interface div_unit_if #(
   parameter int unsigned WIDTH = 32
);
   logic                 start_i;
   logic                 annul_i;
   logic                 signed_div_i;
   logic [WIDTH-1:0]     opdata1_i;
   logic [WIDTH-1:0]     opdata2_i;
   logic [2*WIDTH-1:0]   result_o;
   logic                 ready_o;
   logic                 stallreq_o;

   modport master (
      output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
      input  result_o, ready_o, stallreq_o
   );

   modport slave (
      input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
      output result_o, ready_o, stallreq_o
   );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; returns {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: finish in one cycle when |dividend| < |divisor|.
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic        clk,
   input logic        rst,
   div_unit_if.slave  bus
);

   localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, BYZERO, ON, END} state_e;

   state_e               state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [WIDTH-1:0]     dvd_q;
   logic [WIDTH-1:0]     dvs_q;
   logic [WIDTH-1:0]     rem_q;
   logic                 neg_quo_q;
   logic                 neg_rem_q;
   logic                 ready_q;
   logic [2*WIDTH-1:0]   result_q;

   logic                 op1_neg;
   logic                 op2_neg;
   logic [WIDTH-1:0]     mag1;
   logic [WIDTH-1:0]     mag2;
   logic [WIDTH:0]       partial;
   logic [WIDTH-1:0]     diff;
   logic                 step_ok;
   logic [WIDTH-1:0]     rem_d;
   logic [WIDTH-1:0]     dvd_d;
   logic [WIDTH-1:0]     quo_fix;
   logic [WIDTH-1:0]     rem_fix;

   // Operand magnitudes for signed division
   always_comb begin
      op1_neg = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
      op2_neg = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
      mag1    = op1_neg ? WIDTH'(WIDTH'(0) - bus.opdata1_i) : bus.opdata1_i;
      mag2    = op2_neg ? WIDTH'(WIDTH'(0) - bus.opdata2_i) : bus.opdata2_i;
   end

   // One restoring step; the extra partial bit keeps divisors above 2^(WIDTH-1) exact
   always_comb begin
      partial = {rem_q, dvd_q[WIDTH-1]};
      step_ok = (partial >= {1'b0, dvs_q});
      diff    = WIDTH'(partial - {1'b0, dvs_q});
      rem_d   = step_ok ? diff : partial[WIDTH-1:0];
      dvd_d   = {dvd_q[WIDTH-2:0], step_ok};
      quo_fix = neg_quo_q ? WIDTH'(WIDTH'(0) - dvd_d) : dvd_d;
      rem_fix = neg_rem_q ? WIDTH'(WIDTH'(0) - rem_d) : rem_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         dvd_q     <= '0;
         dvs_q     <= '0;
         rem_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         ready_q   <= 1'b0;
         result_q  <= '0;
      end else begin
         ready_q  <= 1'b0;
         result_q <= '0;
         if (bus.annul_i) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (bus.start_i) begin
                     if (bus.opdata2_i == '0) begin
                        state_q <= BYZERO;
`ifdef DIV_EARLY_OUT_EN
                     end else if (mag1 < mag2) begin
                        state_q  <= END;
                        ready_q  <= 1'b1;
                        result_q <= {bus.opdata1_i, WIDTH'(0)};
`endif
                     end else begin
                        state_q   <= ON;
                        cnt_q     <= '0;
                        dvd_q     <= mag1;
                        dvs_q     <= mag2;
                        rem_q     <= '0;
                        neg_quo_q <= op1_neg ^ op2_neg;
                        neg_rem_q <= op1_neg;
                     end
                  end
               end
               BYZERO: begin
                  if (!bus.start_i) begin
                     state_q <= IDLE;
                  end else begin
                     state_q <= END;
                     ready_q <= 1'b1;
                  end
               end
               ON: begin
                  if (!bus.start_i) begin
                     state_q <= IDLE;
                  end else begin
                     dvd_q <= dvd_d;
                     rem_q <= rem_d;
                     cnt_q <= cnt_q + CNT_W'(1);
                     if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_q  <= END;
                        ready_q  <= 1'b1;
                        result_q <= {rem_fix, quo_fix};
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   // Stall drops in the END cycle so the pipeline advances on the next edge
   assign bus.stallreq_o = rst & bus.start_i & ~bus.annul_i & (state_q != END);
   assign bus.ready_o    = ready_q;
   assign bus.result_o   = result_q;

endmodule
